// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller and the forwarding logic.
// Pure declarations: no latency, no handshake.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_ERROR    = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs, stage controls and perf counters.
// Master drives the pipeline status, slave (the controller) drives the controls.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_jump;
  logic             ex_memtoreg;
  logic [4:0]       ex_write_reg;
  logic             ex_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             pc_sel_branch;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
           ex_memtoreg, ex_write_reg, ex_branch_taken, dmem_req, dmem_ready,
    input  pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_bubble, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
           ex_memtoreg, ex_write_reg, ex_branch_taken, dmem_req, dmem_ready,
    output pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_bubble, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
// Purely combinational, zero latency, no handshake.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_memtoreg,
  input  logic [4:0] ex_write_reg,
  output logic       lu
);
  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == ex_write_reg);
  assign rt_hit = id_uses_rt && (id_rt == ex_write_reg);
  // $zero is never a real producer, so a load targeting it cannot create a hazard.
  assign lu     = ex_memtoreg && (ex_write_reg != REG_ZERO) && (rs_hit || rt_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stage enable/flush/bubble sequencer for load-use, branch, jump and slow data memory.
// Controls are combinational (zero latency); a stalled dmem access freezes every stage.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;

  hz_state_e         state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic              lu;
  logic              freeze;

  load_use_detect u_load_use_detect (
    .id_rs        (hz.id_rs),
    .id_rt        (hz.id_rt),
    .id_uses_rs   (hz.id_uses_rs),
    .id_uses_rt   (hz.id_uses_rt),
    .ex_memtoreg  (hz.ex_memtoreg),
    .ex_write_reg (hz.ex_write_reg),
    .lu           (lu)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    freeze  = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (hz.dmem_req && !hz.dmem_ready) begin
          freeze  = 1'b1;
          state_d = HZ_MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      HZ_MEM_WAIT: begin
        if (!hz.dmem_ready) begin
          freeze = 1'b1;
          if (wcnt_q >= WCNT_W'(MEM_TIMEOUT - 1)) state_d = HZ_ERROR;
          else                                    wcnt_d  = wcnt_q + WCNT_W'(1);
        end else begin
          state_d = HZ_RUN;
          wcnt_d  = '0;
        end
      end
      HZ_ERROR: freeze = 1'b1;
      default: begin
        state_d = HZ_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // Released cycles (RUN or MEM_WAIT with ready) all share the branch > load-use > jump ladder.
  always_comb begin
    hz.pc_en         = 1'b1;
    hz.pc_sel_branch = 1'b0;
    hz.ifid_en       = 1'b1;
    hz.ifid_flush    = 1'b0;
    hz.idex_en       = 1'b1;
    hz.idex_flush    = 1'b0;
    hz.exmem_en      = 1'b1;
    hz.memwb_bubble  = 1'b0;
    if (freeze) begin
      hz.pc_en        = 1'b0;
      hz.ifid_en      = 1'b0;
      hz.idex_en      = 1'b0;
      hz.exmem_en     = 1'b0;
      hz.memwb_bubble = 1'b1;
    end else if (hz.ex_branch_taken) begin
      hz.pc_sel_branch = 1'b1;
      hz.ifid_flush    = 1'b1;
      hz.idex_flush    = 1'b1;
    end else if (lu) begin
      hz.pc_en      = 1'b0;
      hz.ifid_en    = 1'b0;
      hz.idex_flush = 1'b1;
    end else if (hz.id_jump) begin
      hz.ifid_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hz.pc_en && (stall_cnt_q != '1))     stall_cnt_d = stall_cnt_q + 1'b1;
    if (hz.ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    mem_err_d = mem_err_q || (state_d == HZ_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HZ_RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign hz.mem_err   = mem_err_q;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequencing controller for the 5-stage MIPS pipeline, placed beside the decode-stage control unit. It generates the per-stage enable, flush and bubble signals for four cases: load-use interlocks, taken branches resolved in EX, jumps decoded in ID, and multi-cycle data-memory accesses signalled by a req/ready handshake. It also keeps stall and flush counters for performance monitoring, and latches a sticky error when a memory access times out.

Parameters:
MEM_TIMEOUT, 16, number of consecutive MEM_WAIT cycles without dmem_ready before entering ERROR (minimum 2).
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  instruction in ID reads rs
id_uses_rt  in  1  instruction in ID reads rt
id_jump  in  1  jump decoded in ID
ex_memtoreg  in  1  instruction in EX is a load
ex_write_reg  in  5  destination register of the instruction in EX
ex_branch_taken  in  1  branch resolved taken in EX
dmem_req  in  1  MEM stage requests a data-memory access
dmem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC register load enable
pc_sel_branch  out  1  PC loads the branch target
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID becomes a nop (32'b0)
idex_en  out  1  ID/EX register enable
idex_flush  out  1  ID/EX control bits cleared
exmem_en  out  1  EX/MEM register enable
memwb_bubble  out  1  MEM/WB receives a bubble
mem_err  out  1  sticky memory timeout flag
stall_cnt  out  CNT_W  count of cycles with pc_en=0
flush_cnt  out  CNT_W  count of cycles with ifid_flush=1

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Reset value is RUN. Reset clears the wait counter, stall_cnt, flush_cnt and mem_err.
- Outputs are combinational from the current state and inputs (zero latency). Counters and state update on the clock edge.
- Default in RUN with no event: pc_en, ifid_en, idex_en and exmem_en are 1; all flush, bubble and select outputs are 0.
- Load-use hazard (lu): ex_memtoreg, ex_write_reg != 0, and a match (id_uses_rs and id_rs == ex_write_reg) or (id_uses_rt and id_rt == ex_write_reg).
- Priority within RUN is memory wait, then branch, then load-use, then jump.
- Memory wait (dmem_req and not dmem_ready):
  - All stage enables are 0; memwb_bubble is 1; next state is MEM_WAIT.
  - Branch, load-use and jump are ignored this cycle and re-evaluated after release.
- Branch (ex_branch_taken): pc_en=1, pc_sel_branch=1, ifid_flush=1, idex_flush=1. Load-use and jump are ignored.
- Load-use (lu): pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble is inserted because the load leaves EX on the next cycle.
- Jump (id_jump): ifid_flush=1 only.
- MEM_WAIT state:
  - While dmem_ready=0: everything stays frozen as above and the wait counter increments.
  - When the counter reaches MEM_TIMEOUT-1 with ready still 0, next state is ERROR.
  - When dmem_ready=1 in this state: the pipeline releases in the same cycle and RUN priority is applied to the current inputs. Next state is RUN and the wait counter clears.
- A single-cycle access (dmem_req and dmem_ready together in RUN) never enters MEM_WAIT.
- ERROR state: mem_err=1, all enables are 0, memwb_bubble is 1. The state is left only via rst_n.
- Counters: stall_cnt increments in every cycle with pc_en=0 (including ERROR); flush_cnt increments in every cycle with ifid_flush=1. Both saturate at all-ones; there is no wrap.
- Reset asserted mid-operation forces RUN and zero counters immediately (asynchronous). Outputs then show the RUN defaults for the current inputs.

Decomposition:
- defines.v gains:
  - state encodings HZ_RUN=2'd0, HZ_MEM_WAIT=2'd1, HZ_ERROR=2'd2;
  - the REG_ZERO=5'd0 constant.
- One combinational sub-module, load_use_detect (inputs id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memtoreg, ex_write_reg; output lu). It is reused by the forwarding unit.

Test Plan:
- Load-use: ex_memtoreg=1, ex_write_reg=8, id_rs=8, id_uses_rs=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle; stall_cnt 0->1. With ex_write_reg=0 -> no stall.
- Taken branch concurrent with load-use and id_jump -> pc_sel_branch=1, ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt +1.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all enables 0 and memwb_bubble=1 for 3 cycles; release on the 4th cycle; stall_cnt=3; state back to RUN.
- Timeout: dmem_req=1, ready held 0 for MEM_TIMEOUT=16 cycles -> mem_err=1 from the next cycle; pipeline stays frozen; a later dmem_ready=1 has no effect; rst_n low clears mem_err.
- Reset mid-wait: rst_n pulsed low during MEM_WAIT -> immediate RUN, stall_cnt=0, flush_cnt=0, enables return to 1.
- Saturation: preload or force stall_cnt to all-ones, then stall -> value stays all-ones.
